// File: rtl/gemm_drain_pkg.sv
// Shared types and sizing helpers for the GEMM result drain stage.
package gemm_drain_pkg;

  // Drain control states.
  typedef enum logic {
    IDLE,
    DRAIN
  } state_e;

  // Index width for a count of n items, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DefaultDim  = 16;
  // Row-index width for the default array size.
  localparam int unsigned DefaultRowW = idx_width(DefaultDim);

endpackage

// File: rtl/gemm_drain_if.sv
// Capture and row-stream signals between GEMM array, drain stage and consumer.
interface gemm_drain_if
  import gemm_drain_pkg::*;
#(
  parameter int unsigned DIM     = 16,
  parameter int unsigned IN_BITS = 16,
  parameter int unsigned OUT_W   = 8
);
  localparam int unsigned RowW = idx_width(DIM);
  localparam int unsigned ShW  = idx_width(IN_BITS);

  logic [DIM-1:0][DIM-1:0][IN_BITS-1:0] res_in;
  logic                                 res_valid;
  logic                                 res_ready;
  logic [ShW-1:0]                       shift;
  logic [DIM-1:0][OUT_W-1:0]            out_data;
  logic [RowW-1:0]                      out_row;
  logic                                 out_last;
  logic                                 out_sat;
  logic                                 out_valid;
  logic                                 out_ready;
  logic                                 overrun;

  // Producer/consumer side (array plus downstream).
  modport master (
    output res_in, res_valid, shift, out_ready,
    input  res_ready, out_data, out_row, out_last, out_sat, out_valid, overrun
  );

  // Drain stage side.
  modport slave (
    input  res_in, res_valid, shift, out_ready,
    output res_ready, out_data, out_row, out_last, out_sat, out_valid, overrun
  );

endinterface

// File: rtl/requant_sat.sv
// One-element requantizer: logical right shift with unsigned saturation.
module requant_sat
  import gemm_drain_pkg::*;
#(
  parameter int unsigned IN_BITS = 16,
  parameter int unsigned OUT_W   = 8,
  localparam int unsigned ShW    = idx_width(IN_BITS)
) (
  input  logic [IN_BITS-1:0] value,
  input  logic [ShW-1:0]     shift,
  output logic [OUT_W-1:0]   q,
  output logic               sat
);

  logic [IN_BITS-1:0] shifted;
  logic               over;

  // Any set bit above the output width means the value does not fit.
  if (OUT_W < IN_BITS) begin : g_narrow
    assign over = |shifted[IN_BITS-1:OUT_W];
  end else begin : g_full
    assign over = 1'b0;
  end

  // Shift, then clamp to all ones on overflow.
  always_comb begin
    shifted = value >> shift;
    sat     = over;
    q       = over ? {OUT_W{1'b1}} : shifted[OUT_W-1:0];
  end

endmodule

// File: rtl/gemm_drain.sv
// Snapshots the GEMM accumulator matrix with requantization and streams it row by row.
module gemm_drain
  import gemm_drain_pkg::*;
#(
  parameter int unsigned DIM     = 16,
  parameter int unsigned IN_BITS = 16,
  parameter int unsigned OUT_W   = 8
) (
  input  logic         clk,
  input  logic         reset,
  gemm_drain_if.slave  bus
);

  localparam int unsigned     RowW    = idx_width(DIM);
  localparam logic [RowW-1:0] LastRow = RowW'(DIM - 1);

  state_e                           state_q, state_d;
  logic [RowW-1:0]                  row_q, row_d;
  logic [DIM-1:0][DIM-1:0][OUT_W-1:0] snap_q, quant;
  logic [DIM-1:0][DIM-1:0]          sat_el;
  logic [DIM-1:0]                   sat_row, sat_q;
  logic                             overrun_q;
  logic                             at_last, handshake, ready, capture;

  for (genvar r = 0; r < DIM; r++) begin : g_row
    for (genvar c = 0; c < DIM; c++) begin : g_col
      requant_sat #(
        .IN_BITS(IN_BITS),
        .OUT_W  (OUT_W)
      ) u_requant (
        .value(bus.res_in[r][c]),
        .shift(bus.shift),
        .q    (quant[r][c]),
        .sat  (sat_el[r][c])
      );
    end
    assign sat_row[r] = |sat_el[r];
  end

  // Handshake and capture qualification; res_ready may follow out_ready on the last row.
  always_comb begin
    at_last   = (row_q == LastRow);
    handshake = (state_q == DRAIN) && bus.out_ready;
    ready     = (state_q == IDLE) || (handshake && at_last);
    capture   = bus.res_valid && ready;
  end

  // State and row registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
    end
  end

  // Next state: a capture on the final handshake chains straight into the next job.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    case (state_q)
      IDLE: begin
        if (capture) begin
          state_d = DRAIN;
          row_d   = '0;
        end
      end
      DRAIN: begin
        if (handshake) begin
          if (at_last) begin
            state_d = capture ? DRAIN : IDLE;
            row_d   = '0;
          end else begin
            row_d = row_q + RowW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are zeroed while idle so nothing stale is visible.
  always_comb begin
    bus.res_ready = ready;
    bus.out_valid = (state_q == DRAIN);
    bus.out_row   = row_q;
    bus.out_last  = (state_q == DRAIN) && at_last;
    bus.out_sat   = (state_q == DRAIN) && sat_q[row_q];
    bus.out_data  = (state_q == DRAIN) ? snap_q[row_q] : '0;
    bus.overrun   = overrun_q;
  end

  // Snapshot buffer and sticky overrun flag; dropped pulses never touch the snapshot.
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_q    <= '0;
      sat_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (capture) begin
        snap_q <= quant;
        sat_q  <= sat_row;
      end
      if (bus.res_valid && !ready) begin
        overrun_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gemm_drain.sv
// Randomized scoreboard bench for gemm_drain against a matrix-level reference model.
module tb_gemm_drain;

  localparam int unsigned DIM     = 4;
  localparam int unsigned IN_BITS = 16;
  localparam int unsigned OUT_W   = 8;
  localparam int unsigned MaxQ    = (1 << OUT_W) - 1;

  typedef logic [DIM-1:0][DIM-1:0][IN_BITS-1:0] mat_t;
  typedef logic [DIM-1:0][OUT_W-1:0]            row_t;
  typedef struct {
    row_t data;
    int   row;
    bit   last;
    bit   sat;
  } beat_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;
  int   rmode;
  int   cyc;
  bit   exp_overrun;
  bit   exp_ready;
  beat_t sb[$];

  gemm_drain_if #(.DIM(DIM), .IN_BITS(IN_BITS), .OUT_W(OUT_W)) bus ();

  gemm_drain #(
    .DIM    (DIM),
    .IN_BITS(IN_BITS),
    .OUT_W  (OUT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endfunction

  // Reference: each row of the result is the matrix row shifted and clamped.
  function automatic void push_job(input mat_t m, input logic [3:0] sh);
    for (int i = 0; i < DIM; i++) begin
      beat_t b;
      b.sat = 1'b0;
      b.data = '0;
      for (int j = 0; j < DIM; j++) begin
        int unsigned s;
        s = int'(m[i][j]) >> sh;
        if (s > MaxQ) begin
          b.data[j] = '1;
          b.sat = 1'b1;
        end else begin
          b.data[j] = OUT_W'(s);
        end
      end
      b.row  = i;
      b.last = (i == DIM - 1);
      sb.push_back(b);
    end
  endfunction

  // Monitor: compare presented outputs with the scoreboard, then advance the model.
  always @(negedge clk) begin
    exp_ready = (sb.size() == 0) || (sb.size() == 1 && bus.out_ready);
    chk("res_ready", 64'(bus.res_ready), 64'(exp_ready));
    chk("overrun", 64'(bus.overrun), 64'(exp_overrun));
    chk("out_valid", 64'(bus.out_valid), 64'(sb.size() != 0));
    if (sb.size() != 0) begin
      chk("out_data", 64'(bus.out_data), 64'(sb[0].data));
      chk("out_row", 64'(bus.out_row), 64'(sb[0].row));
      chk("out_last", 64'(bus.out_last), 64'(sb[0].last));
      chk("out_sat", 64'(bus.out_sat), 64'(sb[0].sat));
    end else begin
      chk("idle_outputs", 64'({bus.out_data, bus.out_row, bus.out_last, bus.out_sat}), 64'(0));
    end
    if (reset) begin
      sb.delete();
      exp_overrun = 1'b0;
    end else begin
      if (sb.size() != 0 && bus.out_ready) void'(sb.pop_front());
      if (bus.res_valid) begin
        if (exp_ready) push_job(bus.res_in, bus.shift);
        else exp_overrun = 1'b1;
      end
    end
  end

  // out_ready driver: 0 = always ready, 1 = 1,0,0,1 pattern, 2 = random.
  always @(posedge clk) begin
    #1;
    cyc++;
    case (rmode)
      1:       bus.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      2:       bus.out_ready = 1'($urandom_range(0, 1));
      default: bus.out_ready = 1'b1;
    endcase
  end

  function automatic mat_t rand_mat();
    mat_t m;
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++)
        m[i][j] = IN_BITS'($urandom_range(0, 65535) >> $urandom_range(0, 15));
    return m;
  endfunction

  task automatic send_job(input mat_t m, input logic [3:0] sh);
    bus.res_in    = m;
    bus.shift     = sh;
    bus.res_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.res_valid = 1'b0;
    bus.res_in    = rand_mat();
    bus.shift     = 4'($urandom_range(0, 15));
  endtask

  task automatic wait_row(input int r);
    int n;
    n = 0;
    while (!(bus.out_valid && bus.out_row == r) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) begin
      n_checks++;
      $display("FAIL wait_row: row %0d never presented", r);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.out_valid && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 400) begin
      n_checks++;
      $display("FAIL wait_idle: drain never finished, out_valid=%0b", bus.out_valid);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    mat_t m;
    n_checks      = 0;
    n_pass        = 0;
    rmode         = 0;
    cyc           = 0;
    exp_overrun   = 1'b0;
    reset         = 1'b1;
    bus.res_valid = 1'b0;
    bus.res_in    = '0;
    bus.shift     = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Ramp matrix, pass-through shift.
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) m[i][j] = IN_BITS'(16 * i + j);
    send_job(m, 4'd0);
    wait_idle();

    // Single saturating element in row 1.
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) m[i][j] = 16'h0040;
    m[1][3] = 16'h0500;
    send_job(m, 4'd2);
    wait_idle();

    // Backpressure pattern.
    rmode = 1;
    send_job(rand_mat(), 4'($urandom_range(0, 15)));
    wait_idle();
    rmode = 0;

    // Second job lands on the final-row handshake.
    send_job(rand_mat(), 4'd3);
    wait_row(DIM - 1);
    send_job(rand_mat(), 4'd1);
    wait_idle();

    // Pulse while busy must be dropped and flagged.
    send_job(rand_mat(), 4'd0);
    wait_row(1);
    send_job(rand_mat(), 4'd0);
    wait_idle();

    // Reset mid-drain, then a clean job.
    send_job(rand_mat(), 4'd4);
    wait_row(2);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    send_job(rand_mat(), 4'd2);
    wait_idle();

    // Random jobs, gaps, stalls and stray pulses.
    rmode = 2;
    for (int k = 0; k < 30; k++) begin
      send_job(rand_mat(), 4'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 6)) @(posedge clk);
      #1;
    end
    rmode = 0;
    wait_idle();
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
